// File: rtl/led_fade_pkg.sv
// led_fade_pkg: shared types and constants for the LED fade/PWM output slot.
package led_fade_pkg;
  typedef enum logic [1:0] {OFF, RISE, ON, FALL} fade_state_t;
  localparam logic [4:0] CFG_BASE  = 5'd0;
  localparam logic [4:0] CTRL_ADDR = 5'd8;
  localparam logic [4:0] LVL_BASE  = 5'd16;
  localparam int LVL_BITS = 8;
endpackage

// File: rtl/led_fade_chan.sv
// led_fade_chan: one channel's rise/hold/fall ramp FSM with step counter and level.
// Ports: clk, reset (async, active-high), tick (1 ms pulse), blink_in (raw on/off),
//        max_lvl (ramp ceiling), step_ms (ticks per level step), level (current level).
module led_fade_chan
  import led_fade_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                blink_in,
  input  logic [7:0]          max_lvl,
  input  logic [7:0]          step_ms,
  output logic [LVL_BITS-1:0] level
);
  fade_state_t state_q, state_d;
  logic [LVL_BITS-1:0] level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic step0, step;
  assign step0 = step_ms == 8'd0;
  assign step  = tick && !step0 && (cnt_q == step_ms - 8'd1);
  assign level = level_q;
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      OFF: begin
        level_d = step0 && blink_in ? max_lvl : '0;
        if (blink_in) state_d = step0 ? ON : RISE;
      end
      RISE:
        if (!blink_in) state_d = FALL;
        else if (step0 || level_q >= max_lvl) begin
          // Also catches max_lvl being lowered below the current level.
          state_d = ON;
          level_d = max_lvl;
        end else if (step) begin
          level_d = level_q + 1'b1;
          if (level_q + 1'b1 == max_lvl) state_d = ON;
        end
      ON:
        if (!blink_in) begin
          state_d = step0 ? OFF : FALL;
          level_d = step0 ? '0 : level_q;
        end else level_d = max_lvl;
      FALL:
        if (blink_in) state_d = RISE;
        else if (step0 || level_q == '0) begin
          state_d = OFF;
          level_d = '0;
        end else if (step) begin
          level_d = level_q - 1'b1;
          if (level_q == 8'd1) state_d = OFF;
        end
    endcase
    cnt_d = (state_d != state_q || step) ? '0 :
            (tick && (state_q == RISE || state_q == FALL)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= OFF;
      level_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: MMIO slot turning raw blink bits into faded, brightness-limited PWM LED drive.
// Ports: clk, reset (async, active-high); slot bus cs/read/write/addr/wr_data/rd_data;
//        blink_in (raw blink bits), led_pwm (registered LED drive).
// Define LED_FADE_GAMMA_EN to square the level into the duty cycle (gamma correction).
module led_fade_pwm
  import led_fade_pkg::*;
#(
  parameter int W           = 4,
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  input  logic [W-1:0] blink_in,
  output logic [W-1:0] led_pwm
);
  localparam int TICK_N = CLK_FREQ_HZ / 1000;
  localparam int PW     = TICK_N > 1 ? $clog2(TICK_N) : 1;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0] cfg_q [W];
  logic [15:0] cfg_d [W];
  logic [1:0] ctrl_q, ctrl_d;
  logic [7:0] pwm_cnt_q;
  logic [W-1:0] blink_q, led_q, led_d, raw;
  logic [LVL_BITS-1:0] level [W];
  logic tick, wr, unused_ok;
  assign unused_ok = ^{read, wr_data[31:16]};
  assign wr      = cs && write;
  assign tick    = presc_q == PW'(TICK_N - 1);
  assign presc_d = tick ? '0 : presc_q + 1'b1;
  assign led_d   = (ctrl_q[0] ? raw : blink_q) ^ {W{ctrl_q[1]}};
  assign led_pwm = led_q;
  always_comb begin
    ctrl_d = (wr && addr == CTRL_ADDR) ? wr_data[1:0] : ctrl_q;
    for (int i = 0; i < W; i++)
      cfg_d[i] = (wr && addr == CFG_BASE + 5'(i)) ? wr_data[15:0] : cfg_q[i];
  end
  always_comb begin
    rd_data = addr == CTRL_ADDR ? {30'b0, ctrl_q} : '0;
    for (int i = 0; i < W; i++) begin
      if (addr == CFG_BASE + 5'(i)) rd_data = {16'b0, cfg_q[i]};
      if (addr == LVL_BASE + 5'(i)) rd_data = {{(32-LVL_BITS){1'b0}}, level[i]};
    end
  end
  for (genvar g = 0; g < W; g++) begin : g_ch
    logic [7:0] duty;
    led_fade_chan u_chan (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .blink_in (blink_q[g]),
      .max_lvl  (cfg_q[g][7:0]),
      .step_ms  (cfg_q[g][15:8]),
      .level    (level[g])
    );
`ifdef LED_FADE_GAMMA_EN
    logic [15:0] sq;
    assign sq   = level[g] * level[g];
    assign duty = sq[15:8];
`else
    assign duty = level[g];
`endif
    assign raw[g] = pwm_cnt_q < duty;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      presc_q   <= '0;
      ctrl_q    <= '0;
      pwm_cnt_q <= '0;
      blink_q   <= '0;
      led_q     <= '0;
      for (int i = 0; i < W; i++) cfg_q[i] <= '0;
    end else begin
      presc_q   <= presc_d;
      ctrl_q    <= ctrl_d;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      blink_q   <= blink_in;
      led_q     <= led_d;
      for (int i = 0; i < W; i++) cfg_q[i] <= cfg_d[i];
    end
endmodule
